sum_loop_ctrl: RTL and testbench

- Control FSM directly upstream of the 8-bit register-file datapath (RegFile + adder + ≤10 comparator + output register).
- Drives the datapath's mux select, register addresses, write enable and output-register enable, and consumes its R1Le10 status.
- On start, sequences the datapath to compute the running sum 1+2+…+10, publishing each partial sum to OutPort.
- Provides a busy/done handshake, an iteration counter and a runaway-loop guard.

---
 rtl/sum_loop_ctrl.sv | 102 ++++++++++
 tb/tb_sum_loop_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_loop_ctrl.sv
// Control FSM that sequences the 8-bit register-file datapath through the running sum 1+..+10.
// Optional single-step operation is enabled by defining SUM_LOOP_CTRL_STEP_MODE_EN.
module sum_loop_ctrl #(
    parameter logic [7:0] MAX_ITER = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef SUM_LOOP_CTRL_STEP_MODE_EN
    input  logic       step,
`endif
    input  logic       R1Le10,
    output logic       RFSrcMuxSel,
    output logic [2:0] RAddr1,
    output logic [2:0] RAddr2,
    output logic [2:0] WAddr,
    output logic       we,
    output logic       OutPortEn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] iter_count
);

    typedef enum logic [3:0] {
        IDLE, INIT_I, INIT_S, INIT_K, CHECK, ADD_S, OUT, INC_I, DONE
    } state_t;

    state_t state, state_next;
    logic   adv;
    logic   we_raw, oe_raw;

`ifdef SUM_LOOP_CTRL_STEP_MODE_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // IDLE leaves on start alone; every other state advances only when adv is high.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = INIT_I;
            INIT_I: if (adv) state_next = INIT_S;
            INIT_S: if (adv) state_next = INIT_K;
            INIT_K: if (adv) state_next = CHECK;
            CHECK:  if (adv) state_next = (!R1Le10 || iter_count == MAX_ITER) ? DONE : ADD_S;
            ADD_S:  if (adv) state_next = OUT;
            OUT:    if (adv) state_next = INC_I;
            INC_I:  if (adv) state_next = CHECK;
            DONE:   if (adv) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        RFSrcMuxSel = 1'b0;
        RAddr1      = 3'd0;
        RAddr2      = 3'd0;
        WAddr       = 3'd0;
        we_raw      = 1'b0;
        oe_raw      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            INIT_I: begin RFSrcMuxSel = 1'b1; WAddr = 3'd1; we_raw = 1'b1; busy = 1'b1; end
            INIT_S: begin WAddr = 3'd2; we_raw = 1'b1; busy = 1'b1; end
            INIT_K: begin RFSrcMuxSel = 1'b1; WAddr = 3'd3; we_raw = 1'b1; busy = 1'b1; end
            CHECK:  begin RAddr1 = 3'd1; busy = 1'b1; end
            ADD_S:  begin RAddr1 = 3'd2; RAddr2 = 3'd1; WAddr = 3'd2; we_raw = 1'b1; busy = 1'b1; end
            OUT:    begin RAddr1 = 3'd2; oe_raw = 1'b1; busy = 1'b1; end
            INC_I:  begin RAddr1 = 3'd1; RAddr2 = 3'd3; WAddr = 3'd1; we_raw = 1'b1; busy = 1'b1; end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

    assign we        = we_raw & adv;
    assign OutPortEn = oe_raw & adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_count <= 8'd0;
            err        <= 1'b0;
        end else if (adv) begin
            if (state == INIT_I) begin
                iter_count <= 8'd0;
                err        <= 1'b0;
            end else if (state == CHECK && R1Le10 && iter_count == MAX_ITER) begin
                err <= 1'b1;
            end else if (state == INC_I && iter_count != 8'hFF) begin
                iter_count <= iter_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sum_loop_ctrl.sv
// Bench for sum_loop_ctrl: two controllers (default and MAX_ITER=4), each driving a small datapath model.
module tb_sum_loop_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b1;
    logic       start [2];
    logic       r1le10 [2];
    logic       mux [2];
    logic [2:0] ra1 [2];
    logic [2:0] ra2 [2];
    logic [2:0] wa [2];
    logic       we [2];
    logic       oe [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];
    logic [7:0] iter [2];
    logic [7:0] out_port [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [7:0] rf [8];
        logic [7:0] op;

        sum_loop_ctrl #(.MAX_ITER(g == 0 ? 8'd255 : 8'd4)) dut (
            .clk(clk), .reset(reset), .start(start[g]),
`ifdef SUM_LOOP_CTRL_STEP_MODE_EN
            .step(step),
`endif
            .R1Le10(r1le10[g]), .RFSrcMuxSel(mux[g]), .RAddr1(ra1[g]), .RAddr2(ra2[g]),
            .WAddr(wa[g]), .we(we[g]), .OutPortEn(oe[g]), .busy(busy[g]), .done(done[g]),
            .err(err[g]), .iter_count(iter[g])
        );

        function automatic logic [7:0] rd(input logic [2:0] a);
            return (a == 3'd0) ? 8'd0 : rf[a];
        endfunction

        always @(posedge clk) begin
            if (we[g] && wa[g] != 3'd0) rf[wa[g]] <= mux[g] ? 8'd1 : rd(ra1[g]) + rd(ra2[g]);
            if (oe[g]) op <= rd(ra1[g]);
        end

        assign r1le10[g]   = (rd(3'd1) <= 8'd10);
        assign out_port[g] = op;
    end

    function automatic logic [13:0] ctl(input int g);
        return {busy[g], done[g], we[g], oe[g], mux[g], wa[g], ra1[g], ra2[g]};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int g, input int limit);
        int hit = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done[g]) begin hit = 1; break; end
        end
        chk("wait_done", hit, 1);
        @(negedge clk);
    endtask

    // One run checked against the arithmetic of the running sum.
    task automatic run_check(input int g, input bit noisy);
        int n = (g == 0) ? 10 : 4;
        int sum = 0;
        int k = 0;
        int done_at = -1;
        bit pend = 0;
        int exp_vals[$];
        for (int i = 1; i <= n; i++) begin sum += i; exp_vals.push_back(sum); end
        start[g] = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (pend) begin
                chk("out_port", out_port[g], (k < exp_vals.size()) ? exp_vals[k] : -1);
                k++;
                pend = 0;
            end
            if (cyc == 1) chk("busy_after_start", busy[g], 1);
            if (cyc == 2) begin
                chk("err_cleared", err[g], 0);
                chk("iter_cleared", iter[g], 0);
            end
            if (oe[g]) pend = 1;
            if (done[g]) begin done_at = cyc; break; end
            start[g] = (noisy && cyc < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start[g] = 1'b0;
        chk("done_cycle", done_at, 4 * n + 5);
        chk("outen_pulses", k, n);
        chk("iter_final", iter[g], n);
        chk("err_final", err[g], (g == 1) ? 1 : 0);
        @(negedge clk);
        chk("done_one_cycle", done[g], 0);
        chk("iter_held", iter[g], n);
    endtask

    typedef struct {
        bit          st;
        logic [13:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int dones[$];
        start[0] = 1'b0;
        start[1] = 1'b0;

        // reset asserted mid-clock for three cycles
        #3 reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_ctl", ctl(g), 0);
            chk("reset_err", err[g], 0);
            chk("reset_iter", iter[g], 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("post_reset_ctl", ctl(g), 0);
            chk("post_reset_iter", iter[g], 0);
        end

        // {busy,done,we,oe,mux,wa,ra1,ra2} for the first eight cycles of a run
        tbl[0] = '{1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0}};
        tbl[1] = '{1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0}};
        tbl[2] = '{1'b0, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0}};
        tbl[3] = '{1'b1, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0}};
        tbl[4] = '{1'b0, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1}};
        tbl[5] = '{1'b1, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd0}};
        tbl[6] = '{1'b0, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd3}};
        tbl[7] = '{1'b0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0}};
        for (int i = 0; i < 8; i++) begin
            start[0] = tbl[i].st;
            @(negedge clk);
            chk($sformatf("table_row%0d", i), ctl(0), tbl[i].exp);
        end
        start[0] = 1'b0;
        wait_done(0, 60);
        chk("table_run_sum", out_port[0], 55);

        // full runs on both instances, then randomized gaps and start noise while busy
        run_check(0, 1'b0);
        run_check(1, 1'b0);
        run_check(1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_check(r % 2, 1'b1);
        end

        // start held high: back-to-back runs
        start[0] = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (done[0]) begin
                dones.push_back(cyc);
                chk("b2b_sum", out_port[0], 55);
            end
        end
        start[0] = 1'b0;
        chk("b2b_count", dones.size(), 2);
        if (dones.size() >= 2) begin
            chk("b2b_first", dones[0], 45);
            chk("b2b_spacing", dones[1] - dones[0], 46);
        end
        wait_done(0, 60);

        // reset during ADD_S of iteration 5
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_state", ctl(0), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1});
        #2 reset = 1'b1;
        #1;
        chk("midrun_we", we[0], 0);
        chk("midrun_oe", oe[0], 0);
        chk("midrun_iter", iter[0], 0);
        chk("midrun_busy", busy[0], 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_check(0, 1'b0);

`ifdef SUM_LOOP_CTRL_STEP_MODE_EN
        begin
            int pulses = 0;
            int saw_done = 0;
            step = 1'b0;
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            for (int c = 0; c < 20; c++) begin
                chk("step_frozen", ctl(0), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0});
                @(negedge clk);
            end
            for (int s = 0; s < 45; s++) begin
                step = 1'b1;
                @(negedge clk);
                if (oe[0]) pulses++;
                if (done[0]) saw_done = 1;
                step = 1'b0;
                @(negedge clk);
            end
            chk("step_pulses", pulses, 10);
            chk("step_done", saw_done, 1);
            chk("step_sum", out_port[0], 55);
            chk("step_idle", ctl(0), 0);
            step = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
